// File: rtl/sfifo_param_pkg.sv
// Shared types and default parameters for the sfifo_param FIFO.
`include "sfifo_param_def.v"

package sfifo_param_pkg;

  localparam int DEF_WIDTH      = `SFIFO_DEF_WIDTH;
  localparam int DEF_DEPTH_BITS = `SFIFO_DEF_DEPTH_BITS;
  localparam int DEF_TB_DELAY   = `SFIFO_DEF_TB_DELAY;

  // Encoding is {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sfifo_param_def.v
// Shared defaults for the synchronous FIFO: data width, depth exponent and
// the bench half-period.
`ifndef SFIFO_PARAM_DEF_V
`define SFIFO_PARAM_DEF_V
`define SFIFO_DEF_WIDTH      8
`define SFIFO_DEF_DEPTH_BITS 4
`define SFIFO_DEF_TB_DELAY   5
`endif

// File: rtl/sfifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module sfifo_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; only pointers and counter define which words are live.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_param.sv
// Synchronous FIFO with occupancy counter, threshold flags, sticky error flags
// and selectable registered-read or first-word-fall-through output.
module sfifo_param
  import sfifo_param_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_BITS = DEF_DEPTH_BITS,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [DEPTH_BITS:0]   af_level,
  input  logic [DEPTH_BITS:0]   ae_level,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DEPTH_BITS:0]   counter
);

  localparam logic [DEPTH_BITS:0]   DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   HALF_CNT  = {2'b01, {(DEPTH_BITS-1){1'b0}}};
  localparam logic [DEPTH_BITS:0]   CNT_ONE   = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] PTR_ONE   = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [WIDTH-1:0]      head;
  logic                  wr_accept;
  logic                  rd_accept;
  fifo_op_e              op;

  assign empty        = (counter == '0);
  assign full         = (counter == DEPTH_CNT);
  assign half         = (counter >= HALF_CNT);
  assign almost_full  = (counter >= af_level);
  assign almost_empty = (counter <= ae_level);

  // Acceptance looks only at the registered flags, so a full FIFO drops a
  // write even when a read frees a slot in the same cycle (and vice versa).
  assign wr_accept = ~write_n & ~full;
  assign rd_accept = ~read_n & ~empty;
  assign op        = fifo_op_e'({wr_accept, rd_accept});

  sfifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clock (clock),
    .we    (wr_accept & ~reset),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      counter   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;

      case (op)
        OP_WRITE: counter <= counter + CNT_ONE;
        OP_READ:  counter <= counter - CNT_ONE;
        default:  counter <= counter;
      endcase

      if (~write_n & full) overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;

      if (~read_n & empty) underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out   = empty ? '0 : head;
    assign data_valid = ~empty;
  end else begin : g_registered
    always_ff @(posedge clock) begin
      if (reset) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end else begin
        data_valid <= rd_accept;
        if (rd_accept) data_out <= head;
      end
    end
  end

endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param: a registered-read and a FWFT instance share
// the same stimulus; vectors plus hand sequences for the multi-cycle corners.
module tb_sfifo_param;
  import sfifo_param_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int DB = DEF_DEPTH_BITS;

  typedef struct {
    logic         rst;
    logic         wn;
    logic         rn;
    logic         clr;
    logic [W-1:0] din;
    int           cnt;
    logic         valid;
    logic [W-1:0] dout;
    logic         ovf;
    logic         udf;
    logic [W-1:0] fw_dout;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic          write_n = 1'b1;
  logic          read_n = 1'b1;
  logic          clr_err = 1'b0;
  logic [DB:0]   af_level = 5'd12;
  logic [DB:0]   ae_level = 5'd3;

  logic [W-1:0]  data_out, fw_data_out;
  logic          data_valid, fw_data_valid;
  logic          full, empty, half, almost_full, almost_empty, overflow, underflow;
  logic          fw_full, fw_empty, fw_half, fw_almost_full, fw_almost_empty;
  logic          fw_overflow, fw_underflow;
  logic [DB:0]   counter, fw_counter;

  vec_t          vecs[$];
  logic [W-1:0]  model[$];
  int            checks = 0;
  int            errors = 0;

  always #(DEF_TB_DELAY) clock = ~clock;

  sfifo_param #(.WIDTH(W), .DEPTH_BITS(DB), .FWFT(1'b0)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .write_n(write_n),
    .read_n(read_n), .af_level(af_level), .ae_level(ae_level), .clr_err(clr_err),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .half(half), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .counter(counter)
  );

  sfifo_param #(.WIDTH(W), .DEPTH_BITS(DB), .FWFT(1'b1)) dut_fw (
    .clock(clock), .reset(reset), .data_in(data_in), .write_n(write_n),
    .read_n(read_n), .af_level(af_level), .ae_level(ae_level), .clr_err(clr_err),
    .data_out(fw_data_out), .data_valid(fw_data_valid), .full(fw_full),
    .empty(fw_empty), .half(fw_half), .almost_full(fw_almost_full),
    .almost_empty(fw_almost_empty), .overflow(fw_overflow),
    .underflow(fw_underflow), .counter(fw_counter)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rst, input logic wn, input logic rn,
                       input logic clr, input logic [W-1:0] din);
    reset   = rst;
    write_n = wn;
    read_n  = rn;
    clr_err = clr;
    data_in = din;
  endtask

  task automatic add(input logic rst, input logic wn, input logic rn, input logic clr,
                     input logic [W-1:0] din, input int cnt, input logic valid,
                     input logic [W-1:0] dout, input logic ovf, input logic udf,
                     input logic [W-1:0] fw_dout);
    vec_t v;
    v.rst = rst; v.wn = wn; v.rn = rn; v.clr = clr; v.din = din;
    v.cnt = cnt; v.valid = valid; v.dout = dout; v.ovf = ovf; v.udf = udf;
    v.fw_dout = fw_dout;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset, fill 1..16, overflow, drain 1..16, underflow, clear errors.
    add(1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++)
      add(0, 0, 1, 0, W'(i), i, 0, 8'h00, 0, 0, 8'h01);
    add(0, 0, 1, 0, 8'h77, 16, 0, 8'h00, 1, 0, 8'h01);
    for (int j = 1; j <= 16; j++)
      add(0, 1, 0, 0, 8'h00, 16 - j, 1, W'(j), 1, 0, (j < 16) ? W'(j + 1) : 8'h00);
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h10, 1, 1, 8'h00);
    add(0, 1, 1, 1, 8'h00, 0, 0, 8'h10, 0, 0, 8'h00);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].wn, vecs[k].rn, vecs[k].clr, vecs[k].din);
      step();
      check($sformatf("v%0d counter", k), 64'(counter), 64'(vecs[k].cnt));
      check($sformatf("v%0d empty", k), 64'(empty), 64'(vecs[k].cnt == 0));
      check($sformatf("v%0d full", k), 64'(full), 64'(vecs[k].cnt == 16));
      check($sformatf("v%0d half", k), 64'(half), 64'(vecs[k].cnt >= 8));
      check($sformatf("v%0d almost_full", k), 64'(almost_full), 64'(vecs[k].cnt >= 12));
      check($sformatf("v%0d almost_empty", k), 64'(almost_empty), 64'(vecs[k].cnt <= 3));
      check($sformatf("v%0d data_valid", k), 64'(data_valid), 64'(vecs[k].valid));
      check($sformatf("v%0d data_out", k), 64'(data_out), 64'(vecs[k].dout));
      check($sformatf("v%0d overflow", k), 64'(overflow), 64'(vecs[k].ovf));
      check($sformatf("v%0d underflow", k), 64'(underflow), 64'(vecs[k].udf));
      check($sformatf("v%0d fw_valid", k), 64'(fw_data_valid), 64'(vecs[k].cnt != 0));
      check($sformatf("v%0d fw_data_out", k), 64'(fw_data_out), 64'(vecs[k].fw_dout));
    end

    // Preload 8 words, then 40 cycles of simultaneous write and read.
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 0, W'(8'h10 + k));
      step();
      model.push_back(W'(8'h10 + k));
    end
    check("preload counter", 64'(counter), 64'd8);
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] exp;
      drive(0, 0, 0, 0, W'(8'h20 + k));
      step();
      exp = model.pop_front();
      model.push_back(W'(8'h20 + k));
      check($sformatf("stream%0d counter", k), 64'(counter), 64'd8);
      check($sformatf("stream%0d data_out", k), 64'(data_out), 64'(exp));
      check($sformatf("stream%0d data_valid", k), 64'(data_valid), 64'd1);
      check($sformatf("stream%0d fw_head", k), 64'(fw_data_out), 64'(model[0]));
    end

    // Reset mid-stream with counter 9 and both requests asserted.
    drive(0, 0, 1, 0, 8'h99);
    step();
    check("pre-reset counter", 64'(counter), 64'd9);
    drive(1, 0, 0, 0, 8'hEE);
    step();
    model.delete();
    check("reset counter", 64'(counter), 64'd0);
    check("reset empty", 64'(empty), 64'd1);
    check("reset data_valid", 64'(data_valid), 64'd0);
    check("reset data_out", 64'(data_out), 64'd0);
    check("reset fw_valid", 64'(fw_data_valid), 64'd0);
    drive(0, 1, 1, 0, 8'h00);
    step();
    check("post-reset counter", 64'(counter), 64'd0);
    check("post-reset almost_empty", 64'(almost_empty), 64'd1);

    // FWFT: write into empty, head appears next cycle; read drops valid.
    drive(0, 0, 1, 0, 8'hA5);
    step();
    check("fwft data_out", 64'(fw_data_out), 64'hA5);
    check("fwft data_valid", 64'(fw_data_valid), 64'd1);
    check("fwft reg valid idle", 64'(data_valid), 64'd0);
    drive(0, 1, 0, 0, 8'h00);
    step();
    check("fwft valid after read", 64'(fw_data_valid), 64'd0);
    check("reg data_out A5", 64'(data_out), 64'hA5);
    check("reg data_valid pulse", 64'(data_valid), 64'd1);
    drive(0, 1, 1, 0, 8'h00);
    step();
    check("reg valid one cycle", 64'(data_valid), 64'd0);
    check("reg data_out holds", 64'(data_out), 64'hA5);

    // Read while empty with accepted write; set dominates clear.
    drive(0, 0, 0, 0, 8'h3C);
    step();
    check("empty wr+rd counter", 64'(counter), 64'd1);
    check("empty wr+rd underflow", 64'(underflow), 64'd1);
    check("empty wr+rd valid", 64'(data_valid), 64'd0);
    drive(0, 1, 0, 1, 8'h00);
    step();
    check("clr underflow", 64'(underflow), 64'd0);
    check("read 3C", 64'(data_out), 64'h3C);
    drive(0, 1, 0, 1, 8'h00);
    step();
    check("set beats clear", 64'(underflow), 64'd1);
    drive(0, 1, 1, 1, 8'h00);
    step();
    check("clear alone", 64'(underflow), 64'd0);

    // Write while full with accepted read: the write is dropped.
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 0, W'(8'h40 + k));
      step();
    end
    check("refill full", 64'(full), 64'd1);
    drive(0, 0, 0, 0, 8'hFF);
    step();
    check("full wr+rd counter", 64'(counter), 64'd15);
    check("full wr+rd overflow", 64'(overflow), 64'd1);
    check("full wr+rd data_out", 64'(data_out), 64'h40);
    for (int k = 1; k < 16; k++) begin
      drive(0, 1, 0, 0, 8'h00);
      step();
      check($sformatf("drain%0d data_out", k), 64'(data_out), 64'(8'h40 + k));
    end
    drive(0, 1, 1, 0, 8'h00);
    step();
    check("final empty", 64'(empty), 64'd1);
    check("final counter", 64'(counter), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfifo_param.md
SFIFO_PARAM -- requirements
Module: sfifo_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 8: data word width in bits, 1..64.
REQ-003 Parameter DEPTH_BITS, default 4: log2 of storage depth; DEPTH = 2**DEPTH_BITS; legal range 2..10.
REQ-004 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 data_in  input  WIDTH  write data.
REQ-008 write_n  input  1  active-low write request.
REQ-009 read_n  input  1  active-low read request.
REQ-010 af_level  input  DEPTH_BITS+1  almost-full threshold.
REQ-011 ae_level  input  DEPTH_BITS+1  almost-empty threshold.
REQ-012 clr_err  input  1  active-high clear for the sticky error flags.
REQ-013 data_out  output  WIDTH  read data.
REQ-014 data_valid  output  1  data_out holds a valid popped or head word.
REQ-015 full, empty, half, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.
REQ-017 counter  output  DEPTH_BITS+1  current occupancy, 0..DEPTH.

Function
REQ-018 A write SHALL be accepted iff write_n=0 and full=0; a read SHALL be accepted iff read_n=0 and empty=0.
REQ-019 Write and read pointers SHALL be DEPTH_BITS wide and wrap from DEPTH-1 to 0 with no special case.
REQ-020 counter SHALL be +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-021 A write request while full SHALL be dropped, even if a read is accepted in the same cycle.
REQ-022 A read request while empty SHALL be dropped, even if a write is accepted in the same cycle.
REQ-023 Flags SHALL be decoded from the registered counter: empty = (counter==0); full = (counter==DEPTH); half = (counter>=DEPTH/2); almost_full = (counter>=af_level); almost_empty = (counter<=ae_level).
REQ-024 FWFT=0: on an accepted read, data_out SHALL load the head word at that edge, and data_valid SHALL be 1 for exactly the following cycle; otherwise data_out SHALL hold its value.
REQ-025 FWFT=1: data_out SHALL present the head word whenever empty=0, and data_valid SHALL equal ~empty; an accepted read pops the head, and the next word appears after that edge.
REQ-026 FWFT=1, write into an empty FIFO: data_valid SHALL rise on the edge following the write (one-cycle latency).
REQ-027 overflow SHALL set on any cycle with write_n=0 and full=1; underflow SHALL set on any cycle with read_n=0 and empty=1.
REQ-028 Error flags SHALL clear on clr_err=1; a set condition in the same cycle SHALL dominate the clear.
REQ-029 Data order SHALL be strictly first-in first-out across any number of pointer wraps.

Reset
REQ-030 Reset SHALL force pointers=0, counter=0, data_out=0, data_valid=0, overflow=0, underflow=0; hence empty=1, full=half=almost_full=0 and almost_empty=1 (ae_level>=0).
REQ-031 Reset SHALL dominate any write, read or clr_err in the same cycle, including mid-stream; storage contents are not reset.

Structure
REQ-032 Default WIDTH, DEPTH_BITS and the bench delay constant SHALL live in a shared include file, sfifo_param_def.v.
REQ-033 Storage SHALL be a sub-module, sfifo_ram: a DEPTH x WIDTH array with one synchronous write port and one asynchronous read port; pointer, counter and flag logic stays in sfifo_param.

Verification
REQ-034 Scenario 1: DEPTH=16, write 1..16 with no reads -> counter=16, full=1, half=1; a 17th write sets overflow=1 and counter stays 16.
REQ-035 Scenario 2: drain 16 words, then issue one extra read -> data 1..16 in order, empty=1, underflow=1; clr_err clears both error flags.
REQ-036 Scenario 3: with counter=8, perform simultaneous write and read for 40 cycles -> counter stays 8; pointers wrap at least twice; no data mismatch.
REQ-037 Scenario 4: af_level=12, ae_level=3 -> almost_full rises on the edge where counter becomes 12; almost_empty falls when counter becomes 4.
REQ-038 Scenario 5: FWFT=1, write 0xA5 into an empty FIFO -> next cycle data_out=0xA5 and data_valid=1; read -> data_valid=0 next cycle.
REQ-039 Scenario 6: assert reset with counter=9 while write_n=0 and read_n=0 -> next cycle counter=0, empty=1, data_valid=0, and no write lands.
